// File: rtl/zluudg_ma_decimator.sv
// Per-channel boxcar moving average on interleaved I/Q streams, followed by frame decimation.
// Single output register with AXI-Stream handshake, runtime bypass and config-load flush.
module zluudg_ma_decimator #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned MAX_DEPTH_LOG2 = 5,
  parameter int unsigned DECIM_W        = 16,
  parameter int unsigned RST_DEPTH_LOG2 = 3,
  parameter int unsigned RST_DECIM      = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [3:0]          cfg_depth_log2,
  input  logic [DECIM_W-1:0]  cfg_decim_rate,
  input  logic                cfg_bypass,
  input  logic                cfg_load,
  input  logic [2*DATA_W-1:0] s_iq_tdata,
  input  logic                s_iq_tvalid,
  input  logic                s_iq_tlast,
  output logic                s_iq_tready,
  output logic [2*DATA_W-1:0] m_iq_tdata,
  output logic                m_iq_tvalid,
  output logic                m_iq_tlast,
  input  logic                m_iq_tready,
  output logic                err_frame
);

  localparam int unsigned DlLen = 2 ** MAX_DEPTH_LOG2;
  localparam int unsigned AccW  = DATA_W + MAX_DEPTH_LOG2;
  localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IdxW  = (MAX_DEPTH_LOG2 > 0) ? MAX_DEPTH_LOG2 : 1;
  localparam logic [3:0] MaxDepth = 4'(MAX_DEPTH_LOG2);
  localparam logic [3:0] RstDepth = (RST_DEPTH_LOG2 > MAX_DEPTH_LOG2) ? 4'(MAX_DEPTH_LOG2)
                                                                      : 4'(RST_DEPTH_LOG2);
  localparam logic [ChW-1:0] LastCh = ChW'(NUM_CH - 1);

  typedef logic [2*DATA_W-1:0]    iq_t;
  typedef logic signed [AccW-1:0] acc_t;

  iq_t  dl_q    [NUM_CH][DlLen];
  iq_t  dl_d    [NUM_CH][DlLen];
  acc_t acc_i_q [NUM_CH];
  acc_t acc_i_d [NUM_CH];
  acc_t acc_q_q [NUM_CH];
  acc_t acc_q_d [NUM_CH];

  logic [ChW-1:0]     ch_q, ch_d;
  logic [DECIM_W-1:0] frm_q, frm_d;
  logic [DECIM_W-1:0] rate_q, rate_d;
  logic [3:0]         depth_q, depth_d;
  logic               bypass_q, bypass_d;
  logic               sticky_q, sticky_d;
  logic               rdy_q;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  iq_t                m_data_q, m_data_d;
  logic               err_q, err_d;

  logic               s_fire, last_ch, err_in, emit;
  logic [DECIM_W-1:0] rate_eff;
  logic [3:0]         cfg_depth_clamped;
  logic [IdxW:0]      depth_len;
  logic [IdxW-1:0]    drop_idx;
  iq_t                drop_s;
  acc_t               acc_i_sel, acc_q_sel, acc_i_new, acc_q_new;
  logic [DATA_W-1:0]  avg_i, avg_q;

  // Ready is held low through reset and for the first edge after release.
  assign s_iq_tready = rdy_q & ~cfg_load & (~m_valid_q | m_iq_tready);
  assign s_fire      = s_iq_tvalid & s_iq_tready;
  assign last_ch     = (ch_q == LastCh);
  assign err_in      = s_iq_tlast & ~last_ch;
  assign rate_eff    = (rate_q == '0) ? DECIM_W'(1) : rate_q;
  assign emit        = bypass_q | (frm_q == rate_eff - DECIM_W'(1));
  assign cfg_depth_clamped = (cfg_depth_log2 > MaxDepth) ? MaxDepth : cfg_depth_log2;
  assign depth_len   = (IdxW + 1)'(1) << depth_q;
  assign drop_idx    = IdxW'(depth_len - 1'b1);

  always_comb begin
    acc_i_sel = '0;
    acc_q_sel = '0;
    drop_s    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ChW'(c) == ch_q) begin
        acc_i_sel = acc_i_q[c];
        acc_q_sel = acc_q_q[c];
        drop_s    = dl_q[c][drop_idx];
      end
    end
    acc_i_new = acc_i_sel + acc_t'($signed(s_iq_tdata[2*DATA_W-1:DATA_W]))
                          - acc_t'($signed(drop_s[2*DATA_W-1:DATA_W]));
    acc_q_new = acc_q_sel + acc_t'($signed(s_iq_tdata[DATA_W-1:0]))
                          - acc_t'($signed(drop_s[DATA_W-1:0]));
    avg_i = DATA_W'(acc_i_new >>> depth_q);
    avg_q = DATA_W'(acc_q_new >>> depth_q);
  end

  always_comb begin
    ch_d      = ch_q;
    frm_d     = frm_q;
    rate_d    = rate_q;
    depth_d   = depth_q;
    bypass_d  = bypass_q;
    sticky_d  = sticky_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    err_d     = 1'b0;
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    dl_d      = dl_q;

    if (m_valid_q && m_iq_tready) begin
      m_valid_d = 1'b0;
    end

    if (cfg_load) begin
      depth_d   = cfg_depth_clamped;
      rate_d    = cfg_decim_rate;
      bypass_d  = cfg_bypass;
      ch_d      = '0;
      frm_d     = '0;
      sticky_d  = 1'b0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_i_d[c] = '0;
        acc_q_d[c] = '0;
        for (int k = 0; k < DlLen; k++) begin
          dl_d[c][k] = '0;
        end
      end
    end else if (s_fire) begin
      err_d     = err_in;
      ch_d      = (err_in || last_ch) ? '0 : ch_q + 1'b1;
      m_valid_d = emit;
      if (last_ch) begin
        frm_d = (frm_q >= rate_eff - DECIM_W'(1)) ? '0 : frm_q + DECIM_W'(1);
      end
      if (bypass_q) begin
        m_data_d = s_iq_tdata;
        m_last_d = s_iq_tlast;
      end else begin
        if (emit) begin
          m_data_d = {avg_i, avg_q};
          m_last_d = last_ch & (sticky_q | s_iq_tlast);
        end
        // A pending packet end is consumed by the last channel of an emitted frame.
        if (emit && last_ch) begin
          sticky_d = 1'b0;
        end else if (s_iq_tlast) begin
          sticky_d = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
          if (ChW'(c) == ch_q) begin
            acc_i_d[c] = acc_i_new;
            acc_q_d[c] = acc_q_new;
            dl_d[c][0] = s_iq_tdata;
            for (int k = 1; k < DlLen; k++) begin
              dl_d[c][k] = dl_q[c][k-1];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ch_q      <= '0;
      frm_q     <= '0;
      rate_q    <= DECIM_W'(RST_DECIM);
      depth_q   <= RstDepth;
      bypass_q  <= 1'b0;
      sticky_q  <= 1'b0;
      rdy_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_i_q[c] <= '0;
        acc_q_q[c] <= '0;
        for (int k = 0; k < DlLen; k++) begin
          dl_q[c][k] <= '0;
        end
      end
    end else begin
      ch_q      <= ch_d;
      frm_q     <= frm_d;
      rate_q    <= rate_d;
      depth_q   <= depth_d;
      bypass_q  <= bypass_d;
      sticky_q  <= sticky_d;
      rdy_q     <= 1'b1;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      dl_q      <= dl_d;
    end
  end

  assign m_iq_tvalid = m_valid_q;
  assign m_iq_tdata  = m_data_q;
  assign m_iq_tlast  = m_last_q;
  assign err_frame   = err_q;

endmodule
